// File: rtl/mem_bus_arbiter.sv
// Two-client arbiter for a shared line-granular memory bus (A2/D2/C2).
// Issues the owner's command, yields the bus, and returns the response beats to that owner.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 16,
    parameter int CTR_W   = 2,
    parameter int BEATS   = 8,
    parameter int TIMEOUT = 200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              wready0,
    output logic              wready1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] a2,
    inout  wire  [DATA_W-1:0] d2,
    inout  wire  [CTR_W-1:0]  c2
);
    localparam int BW = $clog2(BEATS + 1);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CTR_W-1:0] CMD_READ  = CTR_W'(1);
    localparam logic [CTR_W-1:0] CMD_WRITE = CTR_W'(2);
    localparam logic [CTR_W-1:0] CMD_RESP  = CTR_W'(3);

    typedef enum logic [2:0] {IDLE, CMD, WAIT, RESP, DONE} state_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] a2_q, a2_d;
    logic [CTR_W-1:0]  c2_q, c2_d;
    logic              c2_oe_q, c2_oe_d;
    logic              d2_oe_q, d2_oe_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        wready_q, wready_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic              pick;
    logic              pick_we;
    logic [ADDR_W-1:0] pick_addr;

    // On a tie the client that was not served last wins.
    assign pick      = (req0 & req1) ? ~last_q : req1;
    assign pick_we   = pick ? we1 : we0;
    assign pick_addr = pick ? addr1 : addr0;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        we_d     = we_q;
        a2_d     = a2_q;
        c2_d     = c2_q;
        c2_oe_d  = c2_oe_q;
        d2_oe_d  = d2_oe_q;
        beat_d   = beat_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        gnt_d    = gnt_q;
        wready_d = '0;
        rvalid_d = '0;
        done_d   = '0;
        err_d    = '0;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d        = pick;
                    we_d           = pick_we;
                    a2_d           = pick_addr;
                    gnt_d[pick]    = 1'b1;
                    c2_oe_d        = 1'b1;
                    c2_d           = pick_we ? CMD_WRITE : CMD_READ;
                    d2_oe_d        = pick_we;
                    wready_d[pick] = pick_we;
                    beat_d         = '0;
                    state_d        = CMD;
                end
            end
            CMD: begin
                if (!we_q || beat_q == BW'(BEATS - 1)) begin
                    c2_oe_d = 1'b0;
                    d2_oe_d = 1'b0;
                    a2_d    = '0;
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    // Command code only on the first write beat; data keeps streaming.
                    c2_oe_d           = 1'b0;
                    beat_d            = beat_q + BW'(1);
                    wready_d[owner_q] = 1'b1;
                end
            end
            WAIT: begin
                if (c2 == CMD_RESP) begin
                    if (we_q) begin
                        done_d[owner_q] = 1'b1;
                        state_d         = DONE;
                    end else begin
                        rdata_d           = d2;
                        rvalid_d[owner_q] = 1'b1;
                        beat_d            = BW'(1);
                        state_d           = RESP;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    done_d[owner_q] = 1'b1;
                    err_d[owner_q]  = 1'b1;
                    state_d         = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (beat_q == BW'(BEATS)) begin
                    done_d[owner_q] = 1'b1;
                    state_d         = DONE;
                end else begin
                    rdata_d           = d2;
                    rvalid_d[owner_q] = 1'b1;
                    beat_d            = beat_q + BW'(1);
                end
            end
            DONE: begin
                gnt_d   = '0;
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            a2_q     <= '0;
            c2_q     <= '0;
            c2_oe_q  <= 1'b0;
            d2_oe_q  <= 1'b0;
            beat_q   <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            gnt_q    <= '0;
            wready_q <= '0;
            rvalid_q <= '0;
            done_q   <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            a2_q     <= a2_d;
            c2_q     <= c2_d;
            c2_oe_q  <= c2_oe_d;
            d2_oe_q  <= d2_oe_d;
            beat_q   <= beat_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            gnt_q    <= gnt_d;
            wready_q <= wready_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Write data passes straight from the owner so beat k is on d2 in the cycle wready pulses for it.
    assign d2 = d2_oe_q ? (owner_q ? wdata1 : wdata0) : 'z;
    assign c2 = c2_oe_q ? c2_q : 'z;

    assign a2      = a2_q;
    assign rdata   = rdata_q;
    assign gnt0    = gnt_q[0];
    assign gnt1    = gnt_q[1];
    assign wready0 = wready_q[0];
    assign wready1 = wready_q[1];
    assign rvalid0 = rvalid_q[0];
    assign rvalid1 = rvalid_q[1];
    assign done0   = done_q[0];
    assign done1   = done_q[1];
    assign err0    = err_q[0];
    assign err1    = err_q[1];
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: table of transactions, memory model, read-beat scoreboard.
module tb_mem_bus_arbiter;
    localparam int AW = 15;
    localparam int DW = 16;
    localparam int CTW = 2;
    localparam int NB = 8;
    localparam int TO = 200;
    localparam logic [1:0] C_READ  = 2'd1;
    localparam logic [1:0] C_WRITE = 2'd2;
    localparam logic [1:0] C_RESP  = 2'd3;

    typedef struct {
        bit          c;
        bit          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] base;
        int          delay;
        bit          silent;
        bit          keep;
    } txn_t;

    typedef struct {
        bit          own;
        logic [DW-1:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] req = '0;
    logic [1:0] we = '0;
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wdata [2];
    logic [1:0] gnt, done, err, rvalid, wready;
    logic [DW-1:0] rdata;
    logic [AW-1:0] a2;
    wire  [DW-1:0] d2;
    wire  [CTW-1:0] c2;
    logic mem_d_en = 1'b0;
    logic mem_c_en = 1'b0;
    logic [DW-1:0] mem_d = '0;
    logic [CTW-1:0] mem_c = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rv_cnt [2];
    rd_t exp_q [$];
    rd_t e;
    txn_t tbl [10];

    assign d2 = mem_d_en ? mem_d : 'z;
    assign c2 = mem_c_en ? mem_c : 'z;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CTR_W(CTW), .BEATS(NB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
        .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
        .wready0(wready[0]), .wready1(wready[1]), .gnt0(gnt[0]), .gnt1(gnt[1]),
        .rdata(rdata), .rvalid0(rvalid[0]), .rvalid1(rvalid[1]),
        .done0(done[0]), .done1(done[1]), .err0(err[0]), .err1(err[1]),
        .a2(a2), .d2(d2), .c2(c2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Read scoreboard: each rvalid pops the oldest beat the memory model sent.
    always @(negedge clk) begin
        if (reset) begin
            chk("gnt_exclusive", 32'(gnt == 2'b11), 32'd0);
            if (rvalid != 2'b00) begin
                if (exp_q.size() == 0) begin
                    chk("rvalid_unexpected", 32'(rvalid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rvalid_owner", 32'(rvalid), e.own ? 32'd2 : 32'd1);
                    chk("rdata", 32'(rdata), 32'(e.data));
                    rv_cnt[e.own]++;
                end
            end
        end
    end

    task automatic run_txn(input txn_t t);
        int c0, rm1, exp_done, ncmd, nresp;
        bit fin;
        logic [DW-1:0] bv;
        ncmd  = t.we ? NB : 1;
        nresp = t.we ? 1 : NB;
        req[t.c]   = 1'b1;
        we[t.c]    = t.we;
        addr[t.c]  = t.addr;
        wdata[t.c] = t.base;
        rv_cnt[t.c] = 0;
        fin = 1'b0;
        for (int i = 0; i < 40 && !fin; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) fin = 1'b1;
        end
        chk("grant_owner", 32'(gnt), 32'd1 << t.c);
        c0 = cyc;
        for (int k = 0; k < ncmd; k++) begin
            chk("a2_cmd", 32'(a2), 32'(t.addr));
            if (k == 0) chk("c2_cmd", 32'(c2), t.we ? 32'(C_WRITE) : 32'(C_READ));
            else        chk("c2_released", 32'(c2 === C_WRITE), 32'd0);
            chk("wready", 32'(wready), t.we ? (32'd1 << t.c) : 32'd0);
            if (t.we) chk("d2_write_beat", 32'(d2), 32'(t.base + DW'(k)));
            @(posedge clk); #1;
            if (t.we) wdata[t.c] = t.base + DW'(k + 1);
            if (k < ncmd - 1) @(negedge clk);
        end
        rm1 = c0 + t.delay;
        exp_done = t.silent ? (c0 + ncmd + TO) : (rm1 + 1 + (t.we ? 0 : NB));
        fin = 1'b0;
        for (int i = 0; i < TO + 80 && !fin; i++) begin
            if (!t.silent && cyc >= rm1 && cyc < rm1 + nresp) begin
                bv = t.base + DW'(cyc - rm1);
                mem_d_en = 1'b1;
                mem_d    = bv;
                mem_c_en = (cyc == rm1);
                mem_c    = C_RESP;
                if (!t.we) exp_q.push_back('{own: t.c, data: bv});
            end else begin
                mem_d_en = 1'b0;
                mem_c_en = 1'b0;
            end
            @(negedge clk);
            if (i == 0) begin
                chk("a2_idle_wait", 32'(a2), 32'd0);
                chk("gnt_held", 32'(gnt), 32'd1 << t.c);
            end
            if (done != 2'b00) fin = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        mem_d_en = 1'b0;
        mem_c_en = 1'b0;
        chk("done_seen", 32'(fin), 32'd1);
        if (fin) begin
            chk("done_owner", 32'(done), 32'd1 << t.c);
            chk("done_cycle", 32'(cyc), 32'(exp_done));
            chk("err", 32'(err), t.silent ? (32'd1 << t.c) : 32'd0);
            chk("gnt_at_done", 32'(gnt), 32'd1 << t.c);
            chk("rvalid_count", 32'(rv_cnt[t.c]), (t.we || t.silent) ? 32'd0 : 32'(NB));
            chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        end
        if (!t.keep) req[t.c] = 1'b0;
    endtask

    initial begin
        tbl[0] = '{c: 1'b0, we: 1'b0, addr: 15'h0123, base: 16'h1000, delay: 50, silent: 1'b0, keep: 1'b0};
        tbl[1] = '{c: 1'b1, we: 1'b1, addr: 15'h7FFF, base: 16'h00A0, delay: 12, silent: 1'b0, keep: 1'b0};
        tbl[2] = '{c: 1'b0, we: 1'b1, addr: 15'h0001, base: 16'h5550, delay: 8,  silent: 1'b0, keep: 1'b0};
        tbl[3] = '{c: 1'b1, we: 1'b0, addr: 15'h4000, base: 16'hBEE0, delay: 1,  silent: 1'b0, keep: 1'b0};
        tbl[4] = '{c: 1'b0, we: 1'b0, addr: 15'h0123, base: 16'h0000, delay: 0,  silent: 1'b1, keep: 1'b0};
        tbl[5] = '{c: 1'b1, we: 1'b1, addr: 15'h2222, base: 16'h7700, delay: 0,  silent: 1'b1, keep: 1'b0};
        tbl[6] = '{c: 1'b0, we: 1'b0, addr: 15'h0010, base: 16'h6000, delay: 4,  silent: 1'b0, keep: 1'b1};
        tbl[7] = '{c: 1'b1, we: 1'b0, addr: 15'h0020, base: 16'h6100, delay: 4,  silent: 1'b0, keep: 1'b1};
        tbl[8] = '{c: 1'b0, we: 1'b1, addr: 15'h0030, base: 16'h6200, delay: 9,  silent: 1'b0, keep: 1'b0};
        tbl[9] = '{c: 1'b1, we: 1'b0, addr: 15'h0040, base: 16'h6300, delay: 4,  silent: 1'b0, keep: 1'b0};
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        rv_cnt[0] = 0; rv_cnt[1] = 0;

        #1 reset = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done_err", 32'({done, err}), 32'd0);
        chk("rst_rvalid_wready", 32'({rvalid, wready}), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_a2", 32'(a2), 32'd0);
        chk("rst_c2_free", 32'(c2 === C_READ || c2 === C_WRITE), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            if (i == 6) begin
                req[1] = 1'b1; we[1] = 1'b0; addr[1] = 15'h0020;
            end
            run_txn(tbl[i]);
        end
        @(negedge clk);
        @(negedge clk);

        // Abort a read after beat 3 has been returned.
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 15'h0ABC; rv_cnt[0] = 0;
        for (int i = 0; i < 40 && gnt == 2'b00; i++) @(negedge clk);
        chk("rst_seq_grant", 32'(gnt), 32'd1);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            mem_d_en = 1'b1; mem_d = 16'h2000 + DW'(k);
            mem_c_en = (k == 0); mem_c = C_RESP;
            exp_q.push_back('{own: 1'b0, data: 16'h2000 + DW'(k)});
            @(posedge clk); #1;
        end
        mem_d_en = 1'b0; mem_c_en = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0; req[0] = 1'b0;
        #1;
        chk("midrst_beats_seen", 32'(rv_cnt[0]), 32'd4);
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_done_err", 32'({done, err}), 32'd0);
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        chk("midrst_rdata", 32'(rdata), 32'd0);
        chk("midrst_a2", 32'(a2), 32'd0);
        chk("midrst_c2_free", 32'(c2 === C_READ || c2 === C_WRITE), 32'd0);
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("inrst_quiet", 32'({gnt, done, rvalid}), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        run_txn('{c: 1'b0, we: 1'b0, addr: 15'h0055, base: 16'h3000, delay: 3, silent: 1'b0, keep: 1'b0});

        // Stray RESPONSE while idle must be ignored.
        @(negedge clk);
        @(negedge clk);
        mem_c_en = 1'b1; mem_c = C_RESP; mem_d_en = 1'b1; mem_d = 16'hDEAD;
        repeat (4) begin
            @(negedge clk);
            chk("stray_quiet", 32'({gnt, done, rvalid}), 32'd0);
        end
        mem_c_en = 1'b0; mem_d_en = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
